// File: rtl/demux_pkg.sv
// Shared defaults for the demux dispatcher and the per-channel slice helper.
package demux_pkg;

  localparam int DW_DEF  = 8;
  localparam int NCH_DEF = 8;
  localparam int SW_DEF  = 3;

  // LSB position of channel k inside the flattened out_data bus
  function automatic int chan_lo(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/demux_if.sv
// Producer/consumer bundle of the demux dispatcher; the dispatcher takes the slave side.
interface demux_if
  import demux_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int NCH = NCH_DEF,
  parameter int SW  = SW_DEF
);

  logic [DW-1:0]     In;
  logic [SW-1:0]     Sel;
  logic              in_valid;
  logic              in_ready;
  logic              auto;
  logic [NCH*DW-1:0] out_data;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ack;
  logic [SW-1:0]     scan_idx;
  logic [7:0]        xfer_cnt;

  modport master (
    output In, Sel, in_valid, auto, out_ack,
    input  in_ready, out_data, out_valid, scan_idx, xfer_cnt
  );

  modport slave (
    input  In, Sel, in_valid, auto, out_ack,
    output in_ready, out_data, out_valid, scan_idx, xfer_cnt
  );

endinterface

// File: rtl/demux_chan.sv
// One output slot: loads a word one cycle after a transfer and holds it until acked.
// A load wins over a same-cycle ack so a consumed slot can be refilled without a bubble.
module demux_chan #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          ack,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] data,
  output logic          valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= din;
      valid <= 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_dispatch.sv
// Steers each accepted word to one of NCH slots (Sel or round-robin scan_idx), 1-cycle latency.
// in_ready drops only while the target slot is full and not being acked this cycle.
module demux_dispatch
  import demux_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int NCH = NCH_DEF,
  parameter int SW  = SW_DEF
) (
  input logic    clk,
  input logic    rst,
  demux_if.slave bus
);

  logic [SW-1:0]     target;
  logic              ready;
  logic              xfer;
  logic [SW-1:0]     scan_q;
  logic [7:0]        cnt_q;
  logic [NCH-1:0]    vld;
  logic [NCH*DW-1:0] dat;

  always_comb begin
    target = bus.auto ? scan_q : bus.Sel;
    ready  = !vld[target] | bus.out_ack[target];
    xfer   = bus.in_valid & ready;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    demux_chan #(.DW(DW)) u_chan (
      .clk   (clk),
      .rst   (rst),
      .load  (xfer && (target == SW'(k))),
      .ack   (bus.out_ack[k]),
      .din   (bus.In),
      .data  (dat[chan_lo(k, DW) +: DW]),
      .valid (vld[k])
    );
  end

  // The scan pointer only moves on an auto-mode transfer, so mode toggles leave it intact
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q <= '0;
    end else if (xfer && bus.auto) begin
      scan_q <= (scan_q == SW'(NCH - 1)) ? '0 : scan_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (xfer && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = dat;
  assign bus.out_valid = vld;
  assign bus.scan_idx  = scan_q;
  assign bus.xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_dispatch.sv
// Directed bench for demux_dispatch: stimulus queues hand-computed expectations, a negedge monitor checks them.
module tb_demux_dispatch;

  localparam int K_RDY  = 0;
  localparam int K_VLD  = 1;
  localparam int K_DATA = 2;
  localparam int K_ALL  = 3;
  localparam int K_SCAN = 4;
  localparam int K_CNT  = 5;

  typedef struct {
    int          cyc;
    int          kind;
    int          ch;
    logic [63:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t exp_q[$];

  demux_if #(.DW(8), .NCH(8), .SW(3)) bus ();

  demux_dispatch #(.DW(8), .NCH(8), .SW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] actual(input int kind, input int ch);
    logic [63:0] r;
    r = '0;
    case (kind)
      K_RDY:  r = 64'(bus.in_ready);
      K_VLD:  r = 64'(bus.out_valid);
      K_DATA: r = 64'(bus.out_data[ch*8 +: 8]);
      K_ALL:  r = bus.out_data;
      K_SCAN: r = 64'(bus.scan_idx);
      K_CNT:  r = 64'(bus.xfer_cnt);
      default: r = '1;
    endcase
    return r;
  endfunction

  // Monitor: checks every expectation whose cycle has come, away from the active edge
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      logic [63:0] a;
      e = exp_q.pop_front();
      a = actual(e.kind, e.ch);
      n_total++;
      if (a === e.val) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", e.name, a, e.val);
    end
  end

  task automatic expect_val(input string name, input int kind, input int ch, input logic [63:0] val);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.ch = ch; e.val = val; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic v, input logic au, input logic [2:0] s,
                       input logic [7:0] d, input logic [7:0] ack);
    rst = r; bus.in_valid = v; bus.auto = au; bus.Sel = s; bus.In = d; bus.out_ack = ack;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles with a word offered
    drive(1, 1, 0, 3'd2, 8'hFF, 8'h00);
    tick(); tick();
    drive(0, 0, 0, 3'd0, 8'h00, 8'h00);
    expect_val("rst_valid", K_VLD, 0, 64'h00);
    expect_val("rst_data", K_ALL, 0, 64'h0);
    expect_val("rst_scan", K_SCAN, 0, 64'd0);
    expect_val("rst_cnt", K_CNT, 0, 64'd0);
    expect_val("rst_ready", K_RDY, 0, 64'd1);

    // Manual load then ack of channel 3
    drive(0, 1, 0, 3'd3, 8'hA5, 8'h00);
    expect_val("man_ready", K_RDY, 0, 64'd1);
    tick();
    drive(0, 0, 0, 3'd3, 8'hA5, 8'h00);
    expect_val("man_valid", K_VLD, 0, 64'h08);
    expect_val("man_data3", K_DATA, 3, 64'hA5);
    expect_val("man_cnt", K_CNT, 0, 64'd1);
    drive(0, 0, 0, 3'd3, 8'hA5, 8'h08);
    tick();
    drive(0, 0, 0, 3'd3, 8'hA5, 8'h00);
    expect_val("ack_valid", K_VLD, 0, 64'h00);
    expect_val("ack_data3", K_DATA, 3, 64'hA5);

    // Backpressure on full channel 3, then accept with same-cycle ack
    drive(0, 1, 0, 3'd3, 8'hA5, 8'h00);
    tick();
    drive(0, 1, 0, 3'd3, 8'h5A, 8'h00);
    expect_val("bp_ready", K_RDY, 0, 64'd0);
    tick();
    expect_val("bp_data3", K_DATA, 3, 64'hA5);
    expect_val("bp_valid", K_VLD, 0, 64'h08);
    expect_val("bp_cnt", K_CNT, 0, 64'd2);
    drive(0, 1, 0, 3'd3, 8'h5A, 8'h08);
    expect_val("bpack_ready", K_RDY, 0, 64'd1);
    tick();
    drive(0, 0, 0, 3'd0, 8'h00, 8'h00);
    expect_val("bpack_data3", K_DATA, 3, 64'h5A);
    expect_val("bpack_valid", K_VLD, 0, 64'h08);
    expect_val("bpack_cnt", K_CNT, 0, 64'd3);

    // Stray ack on empty channel 5
    drive(0, 0, 0, 3'd0, 8'h00, 8'h20);
    tick();
    drive(0, 0, 0, 3'd0, 8'h00, 8'h00);
    expect_val("stray_valid", K_VLD, 0, 64'h08);
    expect_val("stray_data5", K_DATA, 5, 64'h00);
    expect_val("stray_cnt", K_CNT, 0, 64'd3);

    // Transfer to channel 2 while channel 3 is acked independently
    drive(0, 1, 0, 3'd2, 8'hC3, 8'h08);
    tick();
    drive(0, 0, 0, 3'd0, 8'h00, 8'h00);
    expect_val("indep_valid", K_VLD, 0, 64'h04);
    expect_val("indep_data2", K_DATA, 2, 64'hC3);
    expect_val("indep_data3", K_DATA, 3, 64'h5A);
    expect_val("indep_cnt", K_CNT, 0, 64'd4);
    expect_val("indep_scan", K_SCAN, 0, 64'd0);

    // Auto scan with all acks asserted: In=0..8
    for (int k = 0; k < 9; k++) begin
      drive(0, 1, 1, 3'd7, 8'(k), 8'hFF);
      expect_val("auto_ready", K_RDY, 0, 64'd1);
      tick();
    end
    drive(0, 0, 1, 3'd0, 8'h00, 8'h00);
    expect_val("auto_valid", K_VLD, 0, 64'h01);
    expect_val("auto_data", K_ALL, 0, 64'h0706050403020108);
    expect_val("auto_scan", K_SCAN, 0, 64'd1);
    expect_val("auto_cnt", K_CNT, 0, 64'd13);

    // Leaving auto mode keeps scan_idx; a manual transfer does not move it
    drive(0, 0, 0, 3'd0, 8'h00, 8'h00);
    tick();
    expect_val("toggle_scan", K_SCAN, 0, 64'd1);
    drive(0, 1, 0, 3'd6, 8'hEE, 8'h00);
    tick();
    drive(0, 0, 0, 3'd0, 8'h00, 8'h00);
    expect_val("man6_scan", K_SCAN, 0, 64'd1);
    expect_val("man6_valid", K_VLD, 0, 64'h41);
    expect_val("man6_cnt", K_CNT, 0, 64'd14);

    // Fill four channels, then reset with a transfer and an ack pending
    drive(0, 1, 0, 3'd1, 8'h11, 8'h00);
    tick();
    drive(0, 1, 0, 3'd2, 8'h22, 8'h00);
    tick();
    drive(0, 0, 0, 3'd0, 8'h00, 8'h00);
    expect_val("fill_valid", K_VLD, 0, 64'h47);
    expect_val("fill_cnt", K_CNT, 0, 64'd16);
    drive(1, 1, 0, 3'd3, 8'h77, 8'h01);
    tick();
    drive(0, 0, 0, 3'd0, 8'h00, 8'h00);
    expect_val("rst2_valid", K_VLD, 0, 64'h00);
    expect_val("rst2_data", K_ALL, 0, 64'h0);
    expect_val("rst2_scan", K_SCAN, 0, 64'd0);
    expect_val("rst2_cnt", K_CNT, 0, 64'd0);
    expect_val("rst2_ready", K_RDY, 0, 64'd1);

    // Saturation: 300 accepted transfers, then 5 more
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 1, 3'd0, 8'(i), 8'hFF);
      tick();
      if (i == 253) expect_val("sat_cnt254", K_CNT, 0, 64'd254);
    end
    expect_val("sat_cnt300", K_CNT, 0, 64'd255);
    for (int i = 0; i < 5; i++) tick();
    drive(0, 0, 1, 3'd0, 8'h00, 8'h00);
    expect_val("sat_cnt305", K_CNT, 0, 64'd255);
    expect_val("sat_scan", K_SCAN, 0, 64'd1);

    // Drain the scoreboard within a bounded number of cycles
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) tick();
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/demux_dispatch.md
DEMUX_DISPATCH -- requirements
Module: demux_dispatch

Interface
REQ-001 Parameters: DW, default 8, data width; NCH, default 8, number of output channels; SW, default 3, select width (log2 NCH).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset. Ports, one per line:
  clk        in   1        clock, all state on rising edge
  rst        in   1        synchronous active-high reset
  In         in   DW       input data word
  Sel        in   SW       target channel (manual mode)
  in_valid   in   1        In/Sel valid this cycle
  in_ready   out  1        block accepts the word this cycle
  auto       in   1        1: target = scan_idx; 0: target = Sel
  out_data   out  NCH*DW   channel k at bits [k*DW+DW-1 : k*DW]
  out_valid  out  NCH      channel k holds an unconsumed word
  out_ack    in   NCH      consumer k takes its word
  scan_idx   out  SW       auto-mode channel pointer
  xfer_cnt   out  8        accepted-word count, saturating

Function
REQ-003 Target channel t SHALL be scan_idx when auto=1, else Sel; evaluated combinationally each cycle.
REQ-004 in_ready SHALL be combinational: !out_valid[t] | out_ack[t].
REQ-005 Transfer occurs when in_valid & in_ready; the next cycle out_data[t] = In and out_valid[t] = 1 (latency 1 cycle).
REQ-006 out_ack[k] with out_valid[k]=1 and no same-cycle transfer to k SHALL clear out_valid[k] the next cycle; out_data[k] SHALL hold its last value.
REQ-007 out_ack[k] with out_valid[k]=0 SHALL be ignored.
REQ-008 A same-cycle ack and transfer on channel k SHALL replace the data; out_valid[k] SHALL stay 1.
REQ-009 Acks on channels other than t SHALL be processed independently in the same cycle as a transfer.
REQ-010 Every transfer made with auto=1 SHALL increment scan_idx modulo NCH (7 -> 0). scan_idx SHALL hold when auto=0 and on stalled cycles.
REQ-011 Toggling auto SHALL NOT modify scan_idx.
REQ-012 xfer_cnt SHALL increment on each transfer in either mode and saturate at 255.
REQ-013 in_valid=1 with in_ready=0 SHALL have no effect on any state; the source holds In/Sel.

Reset
REQ-014 With rst=1 at a clock edge, the following SHALL be 0 the next cycle: out_data, out_valid, scan_idx and xfer_cnt. As a result, in_ready=1.
REQ-015 Reset SHALL take priority over a same-cycle transfer or ack. Words in flight SHALL be discarded, with no partial channel update.

Structure
REQ-016 The shared package demux_pkg SHALL hold DW, NCH and SW defaults and the channel-slice index helper constant.
REQ-017 One sub-module, demux_chan, SHALL be instantiated NCH times. It holds the data register, valid flag and the load/ack logic (REQ-005..008). The top level holds target selection, in_ready, scan_idx and xfer_cnt.
REQ-018 Implementation SHALL fit in 120-400 lines of RTL, with no latches and no multi-driven nets.

Verification
REQ-019 Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=8'h00, out_data=0, scan_idx=0, xfer_cnt=0, in_ready=1.
REQ-020 Manual load: auto=0, Sel=3, In=8'hA5, in_valid for 1 cycle -> next cycle out_valid=8'b0000_1000 and channel 3 data=8'hA5; then out_ack[3] for 1 cycle -> out_valid=0, data stays 8'hA5.
REQ-021 Backpressure: channel 3 full, Sel=3, In=8'h5A, no ack -> in_ready=0 and channel 3 holds 8'hA5. Add out_ack[3] in the same cycle -> accepted, data=8'h5A, out_valid[3] stays 1, xfer_cnt incremented.
REQ-022 Auto scan: auto=1, out_ack=8'hFF, In=0..8 on consecutive cycles -> channel k receives k for k=0..7, channel 0 then receives 8, and scan_idx after the 9th transfer = 1.
REQ-023 Stray ack / reset mid-run: out_ack[5] on an empty channel -> no change. Assert rst while 4 channels are full and in_valid=1 -> all state is 0 the next cycle.
REQ-024 Saturation: 300 accepted transfers -> xfer_cnt=255 and it stays 255.
